// File: rtl/key_pulse_gen_if.sv
// ---------------------------------------------------------------------------
// key_pulse_gen_if
// Groups the pushbutton inputs and the debounced/pulse outputs of
// key_pulse_gen.
//   i_key_n  [1:0]  raw pushbuttons, active-low (bit0 start, bit1 count)
//   o_start         one-cycle start pulse
//   o_count         one-cycle count pulse (press or auto-repeat)
//   o_level  [1:0]  debounced pressed level, 1 = pressed
// master: drives the keys (board / bench); slave: key_pulse_gen.
// ---------------------------------------------------------------------------
interface key_pulse_gen_if;
    logic [1:0] i_key_n;
    logic       o_start;
    logic       o_count;
    logic [1:0] o_level;

    modport master (output i_key_n, input o_start, o_count, o_level);
    modport slave  (input i_key_n, output o_start, o_count, o_level);
endinterface

// File: rtl/key_pulse_gen.sv
// ---------------------------------------------------------------------------
// key_pulse_gen
// Two independent pushbutton channels. Each channel synchronizes its raw
// active-low key, debounces it with a stability counter and turns the
// debounced level into one-cycle pulses: one per press, plus optional
// auto-repeat pulses while the key stays held.
//   i_clk          system clock
//   i_rst          asynchronous, active-low reset
//   bus.i_key_n    raw keys, bit0 start, bit1 count
//   bus.o_start    registered press pulse of channel 0
//   bus.o_count    registered press/repeat pulse of channel 1
//   bus.o_level    debounced pressed level per channel
//
// Per-channel FSM:
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   RELEASED | debounced key up, hold counter parked at 0
//   HELD     | pressed, counting towards the first auto-repeat
//   REPEAT   | auto-repeating, counting towards the next repeat pulse
// ---------------------------------------------------------------------------
module key_pulse_gen #(
    parameter int unsigned CNT_STABLE    = 250000,
    parameter int unsigned REPEAT_DELAY  = 25000000,
    parameter int unsigned REPEAT_PERIOD = 5000000,
    parameter logic [1:0]  REPEAT_EN     = 2'b10
) (
    input  logic            i_clk,
    input  logic            i_rst,
    key_pulse_gen_if.slave  bus
);

    typedef enum logic [1:0] {
        RELEASED = 2'd0,
        HELD     = 2'd1,
        REPEAT   = 2'd2
    } state_t;

    localparam logic [20:0] STAB_LAST = 21'(CNT_STABLE - 1);
    localparam logic [30:0] DELAY_C   = 31'(REPEAT_DELAY);
    localparam logic [30:0] PERIOD_C  = 31'(REPEAT_PERIOD);
    localparam logic [30:0] HOLD_MAX  = '1;

    logic [1:0] level_vec;
    logic [1:0] pulse_vec;

    for (genvar g = 0; g < 2; g++) begin : g_ch
        logic        sync1_q, sync2_q;
        logic [20:0] stab_q, stab_d;
        logic        level_q, level_d;
        logic        flip;
        logic [30:0] hold_q, hold_d, hold_inc;
        state_t      state_q, state_d;
        logic        pulse_q, pulse_d;

        always_ff @(posedge i_clk or negedge i_rst) begin
            if (!i_rst) begin
                sync1_q <= 1'b0;
                sync2_q <= 1'b0;
                stab_q  <= '0;
                level_q <= 1'b0;
                hold_q  <= '0;
                state_q <= RELEASED;
                pulse_q <= 1'b0;
            end else begin
                sync1_q <= ~bus.i_key_n[g];
                sync2_q <= sync1_q;
                stab_q  <= stab_d;
                level_q <= level_d;
                hold_q  <= hold_d;
                state_q <= state_d;
                pulse_q <= pulse_d;
            end
        end

        // Any cycle agreeing with the debounced level restarts the count,
        // so a bounce shorter than CNT_STABLE never flips the level.
        always_comb begin
            stab_d  = '0;
            level_d = level_q;
            flip    = 1'b0;
            if (sync2_q != level_q) begin
                if (stab_q == STAB_LAST) begin
                    flip    = 1'b1;
                    level_d = ~level_q;
                end else begin
                    stab_d = stab_q + 21'd1;
                end
            end
        end

        // Saturating: a key held forever must not wrap into a spurious repeat.
        assign hold_inc = (hold_q == HOLD_MAX) ? hold_q : hold_q + 31'd1;

        // The pulse is decided on the same edge the level flips, so it lines
        // up with the first cycle o_level shows the press. A release takes
        // precedence over a repeat falling due on the same edge.
        always_comb begin
            state_d = state_q;
            hold_d  = hold_q;
            pulse_d = 1'b0;
            if (flip) begin
                hold_d = '0;
                if (level_q) begin
                    state_d = RELEASED;
                end else begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                end
            end else begin
                case (state_q)
                    RELEASED: hold_d = '0;
                    HELD: begin
                        if (REPEAT_EN[g] && (hold_inc == DELAY_C)) begin
                            pulse_d = 1'b1;
                            hold_d  = '0;
                            state_d = REPEAT;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                    REPEAT: begin
                        if (hold_inc == PERIOD_C) begin
                            pulse_d = 1'b1;
                            hold_d  = '0;
                        end else begin
                            hold_d = hold_inc;
                        end
                    end
                    default: begin
                        state_d = RELEASED;
                        hold_d  = '0;
                    end
                endcase
            end
        end

        assign level_vec[g] = level_q;
        assign pulse_vec[g] = pulse_q;
    end

    assign bus.o_level = level_vec;
    assign bus.o_start = pulse_vec[0];
    assign bus.o_count = pulse_vec[1];

endmodule

// File: tb/tb_key_pulse_gen.sv
module tb_key_pulse_gen;

    localparam int         CS  = 4;
    localparam int         RD  = 10;
    localparam int         RP  = 3;
    localparam logic [1:0] REN = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    key_pulse_gen_if bus ();

    key_pulse_gen #(
        .CNT_STABLE   (CS),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP),
        .REPEAT_EN    (REN)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .bus  (bus.slave)
    );

    int checks = 0;
    int passed = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Reference model: a level flips once the synchronized key (raw key two
    // samples late) has disagreed with it on each of the last CS edges since
    // the previous flip; pulses are timestamps relative to the press edge.
    int   m_t = 0;
    int   m_since [2];
    int   m_rise  [2];
    logic m_h0    [2];
    logic m_h1    [2];
    logic m_lvl   [2];
    logic m_pulse [2];
    logic m_hist  [2][64];
    logic m_s, m_flip;

    initial begin
        for (int c = 0; c < 2; c++) begin
            m_since[c] = 0; m_rise[c] = 0; m_h0[c] = 0; m_h1[c] = 0;
            m_lvl[c] = 0; m_pulse[c] = 0;
        end
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int c = 0; c < 2; c++) begin
                    m_h0[c] = 0; m_h1[c] = 0; m_lvl[c] = 0;
                    m_pulse[c] = 0; m_since[c] = m_t;
                end
            end else begin
                m_t++;
                for (int c = 0; c < 2; c++) begin
                    m_s     = m_h1[c];
                    m_h1[c] = m_h0[c];
                    m_h0[c] = ~bus.i_key_n[c];
                    m_hist[c][m_t & 63] = m_s;
                    m_flip = (m_t - m_since[c] >= CS);
                    if (m_flip)
                        for (int j = 0; j < CS; j++)
                            if (m_hist[c][(m_t - j) & 63] == m_lvl[c]) m_flip = 1'b0;
                    m_pulse[c] = 1'b0;
                    if (m_flip) begin
                        m_lvl[c]   = ~m_lvl[c];
                        m_since[c] = m_t;
                        if (m_lvl[c]) begin
                            m_rise[c]  = m_t;
                            m_pulse[c] = 1'b1;
                        end
                    end else if (m_lvl[c] && REN[c] && (m_t - m_rise[c] >= RD)
                                 && ((m_t - m_rise[c] - RD) % RP == 0)) begin
                        m_pulse[c] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst && chk_en) begin
                checks++;
                if (bus.o_level == {m_lvl[1], m_lvl[0]} && bus.o_start == m_pulse[0]
                    && bus.o_count == m_pulse[1])
                    passed++;
                else
                    $display("FAIL model t=%0d: level=%b start=%b count=%b, expected level=%b start=%b count=%b",
                             m_t, bus.o_level, bus.o_start, bus.o_count,
                             {m_lvl[1], m_lvl[0]}, m_pulse[0], m_pulse[1]);
            end
        end
    end

    typedef struct {
        logic [1:0] key_n;
        int         cycles;
        logic [1:0] exp_level;
        int         exp_starts;
        int         exp_counts;
    } vec_t;

    vec_t tbl [11];
    int   ns, nc, rise_c, fall_c, start_at, hi_seen, rem [2];
    int   pq [$];

    initial begin
        tbl[0]  = '{2'b11, 10, 2'b00, 0, 0};
        tbl[1]  = '{2'b01, 40, 2'b10, 0, 10};  // count held: 6,16,19..40
        tbl[2]  = '{2'b11, 20, 2'b00, 0, 1};   // repeat at 3, one at 6 suppressed by release
        tbl[3]  = '{2'b10, 30, 2'b01, 1, 0};   // start held, no repeat
        tbl[4]  = '{2'b11, 20, 2'b00, 0, 0};
        tbl[5]  = '{2'b00, 8,  2'b11, 1, 1};   // both keys together
        tbl[6]  = '{2'b11, 20, 2'b00, 0, 0};
        tbl[7]  = '{2'b01, 3,  2'b00, 0, 0};   // shorter than CNT_STABLE
        tbl[8]  = '{2'b11, 10, 2'b00, 0, 0};
        tbl[9]  = '{2'b01, 4,  2'b00, 0, 0};   // exactly CNT_STABLE: accepted late
        tbl[10] = '{2'b11, 12, 2'b00, 0, 1};

        bus.i_key_n = 2'b11;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_level", int'(bus.o_level), 0);
        check("reset_start", int'(bus.o_start), 0);
        check("reset_count", int'(bus.o_count), 0);
        rst = 1'b1;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        for (int r = 0; r < 11; r++) begin
            bus.i_key_n = tbl[r].key_n;
            ns = 0; nc = 0;
            for (int i = 0; i < tbl[r].cycles; i++) begin
                @(negedge clk);
                if (bus.o_start) ns++;
                if (bus.o_count) nc++;
            end
            check($sformatf("vec%0d_level", r), int'(bus.o_level), int'(tbl[r].exp_level));
            check($sformatf("vec%0d_starts", r), ns, tbl[r].exp_starts);
            check($sformatf("vec%0d_counts", r), nc, tbl[r].exp_counts);
        end

        // start key press timing and release
        bus.i_key_n = 2'b10;
        rise_c = -1; ns = 0; start_at = -1;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (bus.o_level[0] && rise_c < 0) rise_c = i;
            if (bus.o_start) begin ns++; start_at = i; end
        end
        check("press_rise_cycle", rise_c, 6);
        check("press_start_count", ns, 1);
        check("press_start_cycle", start_at, 6);
        bus.i_key_n = 2'b11;
        fall_c = -1; ns = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (!bus.o_level[0] && fall_c < 0) fall_c = i;
            if (bus.o_start) ns++;
        end
        check("release_fall_cycle", fall_c, 6);
        check("release_start_count", ns, 0);

        // bouncing start key, two cycles per phase
        hi_seen = 0; ns = 0;
        for (int i = 0; i < 40; i++) begin
            if (i % 2 == 0) bus.i_key_n[0] = ~bus.i_key_n[0];
            @(negedge clk);
            if (bus.o_level[0]) hi_seen++;
            if (bus.o_start) ns++;
        end
        bus.i_key_n = 2'b11;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.o_level[0]) hi_seen++;
            if (bus.o_start) ns++;
        end
        check("bounce_level_high", hi_seen, 0);
        check("bounce_start_count", ns, 0);

        // reset in the middle of a held count key
        bus.i_key_n = 2'b01;
        repeat (12) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_level", int'(bus.o_level), 0);
        check("midrst_pulses", int'({bus.o_start, bus.o_count}), 0);
        @(negedge clk);
        check("midrst_level2", int'(bus.o_level), 0);
        check("midrst_pulses2", int'({bus.o_start, bus.o_count}), 0);
        @(negedge clk);
        rst = 1'b1;
        pq.delete();
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.o_count) pq.push_back(i);
        end
        check("midrst_npulses", pq.size(), 3);
        check("midrst_pulse0", (pq.size() > 0) ? pq[0] : -1, 6);
        check("midrst_pulse1", (pq.size() > 1) ? pq[1] : -1, 16);
        check("midrst_pulse2", (pq.size() > 2) ? pq[2] : -1, 19);
        check("midrst_level_held", int'(bus.o_level), 2);
        bus.i_key_n = 2'b11;
        repeat (20) @(negedge clk);

        // random key activity against the reference model
        rem[0] = 0; rem[1] = 0;
        for (int cyc = 0; cyc < 1500; cyc++) begin
            for (int c = 0; c < 2; c++) begin
                if (rem[c] == 0) begin
                    bus.i_key_n[c] = ~bus.i_key_n[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                                         : int'($urandom_range(1, 6));
                end else begin
                    rem[c]--;
                end
            end
            if (cyc == 700) rst = 1'b0;
            if (cyc == 702) rst = 1'b1;
            @(negedge clk);
        end
        bus.i_key_n = 2'b11;
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
